// File: rtl/user_rd_reg.sv
// JTAG user read register: snapshots PI on Capture-DR and shifts it out LSB-first on TDO.
// Every flop runs on CLK. The TAP inputs are synchronized, and DRCK is edge-detected rather than used as a clock.
module user_rd_reg #(
  parameter int               width       = 16,
  parameter logic [width-1:0] def_value   = '0,
  parameter int               SYNC_STAGES = 2
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             DRCK,
  input  logic             SEL,
  input  logic             FSEL,
  input  logic             TDI,
  input  logic             CAPTURE,
  input  logic             SHIFT,
  input  logic [width-1:0] PI,
  output logic             TDO,
  output logic             RD_STB,
  output logic             BUSY,
  output logic             OVF
);

  localparam int CNT_W = $clog2(width + 1);

  typedef enum logic [1:0] {IDLE, CAPT, SHFT, DONE} state_t;

  logic [4:0]                  tap_in;
  logic [SYNC_STAGES-1:0][4:0] sync_q, sync_d;
  logic [4:0]                  tap_s;
  logic                        drck_s, sel_s, cap_s, shift_s, tdi_s;
  logic                        drck_prev_q, drck_prev_d;
  logic                        drck_rise, act, cap_ev, shift_ev;

  state_t                      state_q, state_d;
  logic [width-1:0]            sr_q, sr_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic                        ovf_q, ovf_d;
  logic                        rd_stb_q, rd_stb_d;

  // TDI travels alongside SHIFT so the shifted-in bit lines up with its DRCK edge.
  assign tap_in = {TDI, SHIFT, CAPTURE, SEL, DRCK};

  always_comb begin
    sync_d      = {sync_q[SYNC_STAGES-2:0], tap_in};
    drck_prev_d = drck_s;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync_q      <= '0;
      drck_prev_q <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      drck_prev_q <= drck_prev_d;
    end
  end

  assign tap_s     = sync_q[SYNC_STAGES-1];
  assign drck_s    = tap_s[0];
  assign sel_s     = tap_s[1];
  assign cap_s     = tap_s[2];
  assign shift_s   = tap_s[3];
  assign tdi_s     = tap_s[4];
  assign drck_rise = drck_s & ~drck_prev_q;
  assign act       = sel_s & FSEL;
  assign cap_ev    = act & cap_s & drck_rise;
  assign shift_ev  = act & shift_s & drck_rise & ~cap_s;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= IDLE;
      sr_q     <= def_value;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      rd_stb_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sr_q     <= sr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      rd_stb_q <= rd_stb_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (cap_ev) state_d = CAPT;
      CAPT: begin
        if (!act)          state_d = IDLE;
        else if (shift_ev) state_d = SHFT;
      end
      SHFT: begin
        if (!act)          state_d = IDLE;
        else if (cap_ev)   state_d = CAPT;
        else if (!shift_s) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A shift that happens once the count has saturated is what marks an overshift.
  always_comb begin
    sr_d     = sr_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    rd_stb_d = 1'b0;
    if (cap_ev && state_q != DONE) begin
      sr_d  = PI;
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (shift_ev && (state_q == CAPT || state_q == SHFT)) begin
      sr_d = {tdi_s, sr_q[width-1:1]};
      if (cnt_q == CNT_W'(width)) ovf_d = 1'b1;
      else                        cnt_d = cnt_q + 1'b1;
    end
    if (state_q == DONE) rd_stb_d = (cnt_q == CNT_W'(width));
  end

  assign TDO    = FSEL & sr_q[0];
  assign RD_STB = rd_stb_q;
  assign BUSY   = (state_q == CAPT) || (state_q == SHFT);
  assign OVF    = ovf_q;

endmodule

// File: tb/tb_user_rd_reg.sv
// Self-checking bench for user_rd_reg: directed scenarios plus randomized reads against a bit-queue model.
module tb_user_rd_reg;

  localparam int          W   = 16;
  localparam logic [15:0] DEF = 16'hA5A5;

  logic          CLK = 1'b0;
  logic          RST_N, DRCK, SEL, FSEL, TDI, CAPTURE, SHIFT;
  logic [W-1:0]  PI;
  logic          TDO, RD_STB, BUSY, OVF;

  int n_cmp  = 0;
  int n_fail = 0;
  int stb_cnt = 0;

  logic [63:0] o_bits, o_tdis;
  logic        o_busy_mid, o_busy_end, o_ovf_end, o_tdo_end;
  logic        o_tdo_rst, o_busy_rst, o_ovf_rst;
  int          o_stb;

  user_rd_reg #(.width(W), .def_value(DEF), .SYNC_STAGES(2)) dut (
    .CLK(CLK), .RST_N(RST_N), .DRCK(DRCK), .SEL(SEL), .FSEL(FSEL), .TDI(TDI),
    .CAPTURE(CAPTURE), .SHIFT(SHIFT), .PI(PI),
    .TDO(TDO), .RD_STB(RD_STB), .BUSY(BUSY), .OVF(OVF)
  );

  always #5 CLK = ~CLK;

  // Counts high cycles, so one count per read also proves a single-cycle pulse.
  always @(negedge CLK) if (RD_STB === 1'b1) stb_cnt++;

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic drck_pulse();
    DRCK = 1'b1;
    repeat (4) @(negedge CLK);
    DRCK = 1'b0;
    repeat (4) @(negedge CLK);
  endtask

  // end_mode: 0 = SHIFT drops normally, 1 = SEL drops (abort), 2 = reset pulse mid-shift
  task automatic do_read(input logic [15:0] pi, input int n, input int tdi_mode,
                         input bit scramble, input int end_mode);
    int  s0;
    logic t;
    s0 = stb_cnt;
    o_bits = '0;
    o_tdis = '0;
    SEL = 1'b1; FSEL = 1'b1; PI = pi; CAPTURE = 1'b1; SHIFT = 1'b0; TDI = 1'b0;
    repeat (2) @(negedge CLK);
    drck_pulse();
    CAPTURE = 1'b0; SHIFT = 1'b1;
    o_busy_mid = BUSY;
    for (int i = 0; i < n; i++) begin
      t = (tdi_mode == 0) ? 1'b0 : (tdi_mode == 1) ? 1'b1 : 1'($urandom);
      o_tdis[i] = t;
      TDI = t;
      if (scramble) PI = 16'($urandom);
      repeat (2) @(negedge CLK);
      o_bits[i] = TDO;
      drck_pulse();
    end
    case (end_mode)
      1: begin
        SEL = 1'b0;
        repeat (8) @(negedge CLK);
        SHIFT = 1'b0;
        repeat (4) @(negedge CLK);
      end
      2: begin
        RST_N = 1'b0;
        repeat (2) @(negedge CLK);
        o_tdo_rst = TDO; o_busy_rst = BUSY; o_ovf_rst = OVF;
        RST_N = 1'b1;
        SHIFT = 1'b0;
        repeat (8) @(negedge CLK);
      end
      default: begin
        SHIFT = 1'b0;
        repeat (8) @(negedge CLK);
      end
    endcase
    o_busy_end = BUSY; o_ovf_end = OVF; o_tdo_end = TDO;
    o_stb = stb_cnt - s0;
  endtask

  task automatic test_reset();
    RST_N = 1'b0; DRCK = 1'b0; SEL = 1'b1; FSEL = 1'b1; TDI = 1'b1;
    CAPTURE = 1'b1; SHIFT = 1'b0; PI = 16'h0F0F;
    repeat (3) @(negedge CLK);
    drck_pulse();
    drck_pulse();
    n_cmp++; if (TDO !== 1'b1)    begin n_fail++; $display("[TB] FAIL rst_tdo: got %b required 1", TDO); end
    n_cmp++; if (RD_STB !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_stb: got %b required 0", RD_STB); end
    n_cmp++; if (BUSY !== 1'b0)   begin n_fail++; $display("[TB] FAIL rst_busy: got %b required 0", BUSY); end
    n_cmp++; if (OVF !== 1'b0)    begin n_fail++; $display("[TB] FAIL rst_ovf: got %b required 0", OVF); end
    CAPTURE = 1'b0; TDI = 1'b0;
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    repeat (8) @(negedge CLK);
    n_cmp++; if (TDO !== DEF[0])  begin n_fail++; $display("[TB] FAIL rst_tdo_after: got %b required %b", TDO, DEF[0]); end
    n_cmp++; if (BUSY !== 1'b0)   begin n_fail++; $display("[TB] FAIL rst_busy_after: got %b required 0", BUSY); end
  endtask

  task automatic test_full_read();
    logic q[$];
    logic e;
    do_read(16'h1234, 16, 0, 1'b0, 0);
    for (int i = 0; i < W; i++) q.push_back(1'(16'h1234 >> i));
    for (int i = 0; i < 16; i++) begin
      e = q.pop_front();
      q.push_back(o_tdis[i]);
      n_cmp++; if (o_bits[i] !== e) begin n_fail++; $display("[TB] FAIL full_bit[%0d]: got %b required %b", i, o_bits[i], e); end
    end
    n_cmp++; if (o_bits[15:0] !== 16'h1234) begin n_fail++; $display("[TB] FAIL full_word: got %h required 1234", o_bits[15:0]); end
    n_cmp++; if (o_stb !== 1)        begin n_fail++; $display("[TB] FAIL full_stb: got %0d required 1", o_stb); end
    n_cmp++; if (o_ovf_end !== 1'b0) begin n_fail++; $display("[TB] FAIL full_ovf: got %b required 0", o_ovf_end); end
    n_cmp++; if (o_busy_mid !== 1'b1) begin n_fail++; $display("[TB] FAIL full_busy_mid: got %b required 1", o_busy_mid); end
    n_cmp++; if (o_busy_end !== 1'b0) begin n_fail++; $display("[TB] FAIL full_busy_end: got %b required 0", o_busy_end); end
  endtask

  task automatic test_partial_read();
    do_read(16'hBEEF, 7, 2, 1'b0, 0);
    n_cmp++; if (o_bits[6:0] !== 7'(16'hBEEF)) begin n_fail++; $display("[TB] FAIL part_bits: got %h required %h", o_bits[6:0], 7'(16'hBEEF)); end
    n_cmp++; if (o_stb !== 0)         begin n_fail++; $display("[TB] FAIL part_stb: got %0d required 0", o_stb); end
    n_cmp++; if (o_busy_end !== 1'b0) begin n_fail++; $display("[TB] FAIL part_busy: got %b required 0", o_busy_end); end
  endtask

  task automatic test_overshift();
    do_read(16'h0001, 20, 1, 1'b0, 0);
    n_cmp++; if (o_bits[15:0] !== 16'h0001) begin n_fail++; $display("[TB] FAIL ovs_word: got %h required 0001", o_bits[15:0]); end
    n_cmp++; if (o_bits[19:16] !== 4'hF)    begin n_fail++; $display("[TB] FAIL ovs_chain: got %h required f", o_bits[19:16]); end
    n_cmp++; if (o_ovf_end !== 1'b1) begin n_fail++; $display("[TB] FAIL ovs_ovf: got %b required 1", o_ovf_end); end
    n_cmp++; if (o_stb !== 1)        begin n_fail++; $display("[TB] FAIL ovs_stb: got %0d required 1", o_stb); end
  endtask

  task automatic test_abort_snapshot();
    do_read(16'h5A5A, 8, 2, 1'b0, 1);
    n_cmp++; if (o_stb !== 0)         begin n_fail++; $display("[TB] FAIL abort_stb: got %0d required 0", o_stb); end
    n_cmp++; if (o_busy_end !== 1'b0) begin n_fail++; $display("[TB] FAIL abort_busy: got %b required 0", o_busy_end); end
    do_read(16'hFFFF, 16, 0, 1'b1, 0);
    n_cmp++; if (o_bits[15:0] !== 16'hFFFF) begin n_fail++; $display("[TB] FAIL snap_word: got %h required ffff", o_bits[15:0]); end
    n_cmp++; if (o_stb !== 1)        begin n_fail++; $display("[TB] FAIL snap_stb: got %0d required 1", o_stb); end
  endtask

  task automatic test_reset_mid_shift();
    do_read(16'h00F0, 5, 1, 1'b0, 2);
    n_cmp++; if (o_tdo_rst !== DEF[0]) begin n_fail++; $display("[TB] FAIL rms_tdo: got %b required %b", o_tdo_rst, DEF[0]); end
    n_cmp++; if (o_busy_rst !== 1'b0)  begin n_fail++; $display("[TB] FAIL rms_busy: got %b required 0", o_busy_rst); end
    n_cmp++; if (o_ovf_rst !== 1'b0)   begin n_fail++; $display("[TB] FAIL rms_ovf: got %b required 0", o_ovf_rst); end
    n_cmp++; if (o_stb !== 0)          begin n_fail++; $display("[TB] FAIL rms_stb: got %0d required 0", o_stb); end
    n_cmp++; if (o_tdo_end !== DEF[0]) begin n_fail++; $display("[TB] FAIL rms_tdo_hold: got %b required %b", o_tdo_end, DEF[0]); end
    do_read(16'h1234, 16, 0, 1'b0, 0);
    n_cmp++; if (o_bits[15:0] !== 16'h1234) begin n_fail++; $display("[TB] FAIL rms_reread: got %h required 1234", o_bits[15:0]); end
    n_cmp++; if (o_stb !== 1)        begin n_fail++; $display("[TB] FAIL rms_reread_stb: got %0d required 1", o_stb); end
  endtask

  task automatic test_fsel_low();
    int s0;
    s0 = stb_cnt;
    FSEL = 1'b0; SEL = 1'b1; CAPTURE = 1'b1; PI = 16'hFFFF;
    repeat (2) @(negedge CLK);
    n_cmp++; if (TDO !== 1'b0) begin n_fail++; $display("[TB] FAIL fsel_tdo: got %b required 0", TDO); end
    drck_pulse();
    CAPTURE = 1'b0;
    repeat (4) @(negedge CLK);
    n_cmp++; if (BUSY !== 1'b0) begin n_fail++; $display("[TB] FAIL fsel_busy: got %b required 0", BUSY); end
    n_cmp++; if (stb_cnt - s0 !== 0) begin n_fail++; $display("[TB] FAIL fsel_stb: got %0d required 0", stb_cnt - s0); end
    FSEL = 1'b1;
  endtask

  task automatic test_random();
    logic        q[$];
    logic        e;
    logic [15:0] pi;
    int          n, mode, exp_stb;
    for (int it = 0; it < 10; it++) begin
      pi   = 16'($urandom);
      n    = $urandom_range(1, 20);
      mode = ($urandom_range(0, 3) == 0) ? 1 : 0;
      do_read(pi, n, 2, 1'b1, mode);
      q.delete();
      for (int i = 0; i < W; i++) q.push_back(pi[i]);
      for (int i = 0; i < n; i++) begin
        e = q.pop_front();
        q.push_back(o_tdis[i]);
        n_cmp++; if (o_bits[i] !== e) begin n_fail++; $display("[TB] FAIL rnd%0d_bit[%0d]: got %b required %b", it, i, o_bits[i], e); end
      end
      exp_stb = (mode == 0 && n >= W) ? 1 : 0;
      n_cmp++; if (o_stb !== exp_stb) begin n_fail++; $display("[TB] FAIL rnd%0d_stb: got %0d required %0d", it, o_stb, exp_stb); end
      n_cmp++; if (o_ovf_end !== (n > W)) begin n_fail++; $display("[TB] FAIL rnd%0d_ovf: got %b required %b", it, o_ovf_end, (n > W)); end
      n_cmp++; if (o_busy_end !== 1'b0) begin n_fail++; $display("[TB] FAIL rnd%0d_busy: got %b required 0", it, o_busy_end); end
    end
  endtask

  initial begin
    test_reset();
    test_full_read();
    test_partial_read();
    test_overshift();
    test_abort_snapshot();
    test_reset_mid_shift();
    test_fsel_low();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/user_rd_reg.md
# user_rd_reg

Parallel-in serial-out JTAG user read register, the readback counterpart of the user write register. It snapshots a parallel status word on Capture-DR and shifts it out LSB-first on TDO during Shift-DR. All logic runs on the CMS clock: TAP signals are synchronized and DRCK is edge-detected, so no flop is clocked by DRCK. A one-cycle read strobe marks each complete read, which lets upstream logic implement clear-on-read counters.

## Interface
- width, 16, number of bits in the register (2..64)
- def_value, 16'h0000, shift register content after reset
- SYNC_STAGES, 2, synchronizer depth for DRCK/SEL/CAPTURE/SHIFT (≥2)

Ports:
- CLK  in  1  CMS clock; single clock for the whole block
- RST_N  in  1  reset, asynchronous, active-low
- DRCK  in  1  TAP data register clock, sampled as data
- SEL  in  1  user mode active
- FSEL  in  1  function select, quasi-static from instruction decode
- TDI  in  1  serial test data in, used for daisy-chain fill
- CAPTURE  in  1  Capture-DR state
- SHIFT  in  1  Shift-DR state
- PI  in  width  parallel input word, CLK domain
- TDO  out  1  serial test data out, FSEL & sr[0]
- RD_STB  out  1  one-CLK pulse after a complete read
- BUSY  out  1  high while in CAPT or SHFT state
- OVF  out  1  sticky: more than width bits shifted since last capture

## Operation
- DRCK, SEL, CAPTURE and SHIFT each pass through SYNC_STAGES flops. drck_rise = synced DRCK high and previous synced DRCK low. Every action below is qualified by drck_rise.
- act = SEL_s & FSEL.
- FSM states: IDLE, CAPT, SHFT, DONE.
  - IDLE: on act & CAPTURE_s & drck_rise, load sr <= PI, clear bit_cnt and OVF, go to CAPT.
  - CAPT: on act & SHIFT_s & drck_rise, perform a shift and go to SHFT. On act & CAPTURE_s & drck_rise, reload PI. If act drops, go to IDLE.
  - SHFT: on act & SHIFT_s & drck_rise, shift. When SHIFT_s is low and act is high, go to DONE. If act drops, abort to IDLE with no strobe.
  - DONE: assert RD_STB for one cycle only if bit_cnt == width, then go to IDLE.
- Shift operation: sr <= {TDI_s, sr[width-1:1]}. TDI is sampled through the same synchronizer path as SHIFT so it stays aligned.
- bit_cnt is clog2(width+1) bits wide and saturates at width. A shift while bit_cnt == width sets OVF. OVF holds until the next capture.
- Simultaneous CAPTURE_s and SHIFT_s: capture wins and no shift happens.
- PI changes after capture are ignored until the next capture.
- FSEL low forces TDO = 0. The FSM still leaves to IDLE because act is low.

## Timing
- Reset (RST_N low, asynchronous) sets:
  - TDO = FSEL & def_value[0]; sr = def_value.
  - RD_STB = 0, BUSY = 0, OVF = 0.
  - State = IDLE, bit_cnt = 0, all synchronizer flops = 0.
- Latency: a DRCK rising edge is acted on at CLK edge SYNC_STAGES+1 after it. TDO updates one CLK later, from the sr flop through one AND gate.
- CLK must be at least 8× the DRCK frequency. This keeps TDO settled before the TAP samples on the falling TCK edge, and guarantees DRCK high/low phases each span at least 2 CLK periods.
- RD_STB asserts exactly one CLK cycle, 1 CLK after the SHFT→DONE transition.
- BUSY rises with entry to CAPT and falls on entry to IDLE.
- Reset asserted mid-shift: immediate return to the reset values above, with no RD_STB. The first read after reset requires a fresh capture.

## Test plan
- Reset: RST_N low with def_value=16'hA5A5 and FSEL=1 -> TDO=1, RD_STB=0, BUSY=0, OVF=0; state holds while RST_N is low regardless of DRCK activity.
- Full read: PI=16'h1234, one capture, 16 shifts with TDI=0 -> TDO sequence LSB-first 0,0,1,0,1,1,0,0,0,1,0,0,1,0,0,0; one RD_STB pulse after SHIFT drops; OVF=0.
- Partial read: capture, then 7 shifts, then SHIFT drops -> no RD_STB; FSM returns to IDLE; BUSY falls.
- Overshift/daisy chain: capture PI=16'h0001, 20 shifts with TDI=1 -> bits 17..20 out are the first 4 TDI ones; OVF=1; RD_STB=1 once.
- Abort and snapshot: SEL drops after 8 shifts -> IDLE, no RD_STB. Next capture loads the new PI=16'hFFFF, and PI changes during the following shift do not alter the shifted data.
- Reset mid-shift: RST_N pulsed low after 5 shifts -> sr=def_value, bit_cnt=0, no RD_STB; subsequent full read behaves as in the full-read scenario.
